// File: rtl/decoder_strobe.sv
// decoder_strobe: registered one-of-N active-low decoder with an optional timed-strobe mode
module decoder_strobe #(
  parameter int A_WIDTH      = 4,
  parameter int G_COUNT      = 2,
  parameter int MODE         = 0,
  parameter int PULSE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [A_WIDTH-1:0]      a,
  input  logic [G_COUNT-1:0]      g_n,
  input  logic                    start,
  input  logic                    cancel,
  output logic [2**A_WIDTH-1:0]   y_n,
  output logic                    busy
);
  localparam int N  = 2**A_WIDTH;
  localparam int CW = PULSE_CYCLES > 1 ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(PULSE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, STROBE, RECOVER} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [A_WIDTH-1:0] addr, addr_d;
  logic [N-1:0] y_d;
  logic gated, go, done;
  assign gated = ~|g_n;
  assign done  = cnt == '0 || cancel;
  // a start sampled at the end of the recovery cycle is accepted, so recovery still shows one all-high cycle
  assign go    = MODE != 0 && start && gated && state != STROBE;
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    addr_d  = addr;
    if (go) begin
      state_d = STROBE;
      cnt_d   = LOAD;
      addr_d  = a;
    end else if (state == STROBE) begin
      state_d = done ? RECOVER : STROBE;
      cnt_d   = done ? cnt : cnt - CW'(1);
    end else if (state == RECOVER) begin
      state_d = IDLE;
    end
    y_d = MODE != 0 ? (state_d == STROBE ? ~(N'(1) << addr_d) : '1)
                    : (gated ? ~(N'(1) << a) : '1);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      addr  <= '0;
      y_n   <= '1;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      addr  <= addr_d;
      y_n   <= y_d;
      busy  <= state_d != IDLE;
    end
  end
endmodule
